qpd_position_normalizer: RTL and testbench
==========================================

Name: qpd_position_normalizer

Overview:
- Downstream consumer of the QPD demodulator outputs (x1, x2, i1, i2 and the done strobe).
- Computes the intensity-normalized beam position pos = (x1*i1 + x2*i2) / (i1^2 + i2^2):
  - the in-phase projection of the difference channel onto the sum channel,
  - scaled to fixed point with FRAC_BITS fractional bits.
- Uses one shared 2-product multiply stage and an iterative restoring divider (one quotient bit per cycle).
- Result feeds the position readout/telemetry path at demodulator sample rate.

Parameters:
- NUM_BITS, 24, width of the x/i inputs and of pos_o (signed).
- FRAC_BITS, 22, fractional bits of pos_o (1.0 = 2^FRAC_BITS); must satisfy FRAC_BITS < NUM_BITS.
- MIN_INTENSITY_SQ, 1, denominator threshold; den < MIN_INTENSITY_SQ flags the sample invalid.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  sample strobe, connected to demodulator done.
- x1_i  in  NUM_BITS  signed difference-channel sin component.
- x2_i  in  NUM_BITS  signed difference-channel cos component.
- i1_i  in  NUM_BITS  signed sum-channel sin component.
- i2_i  in  NUM_BITS  signed sum-channel cos component.
- pos_o  out  NUM_BITS  signed normalized position, held between results.
- valid_o  out  1  one-cycle result strobe.
- busy_o  out  1  high while a sample is in flight.
- sat_o  out  1  result saturated; qualified by valid_o, held with pos_o.
- invalid_o  out  1  denominator below threshold; qualified by valid_o, held with pos_o.
- overrun_o  out  1  sticky: valid_i arrived while busy; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM to IDLE, all datapath registers 0. Reset mid-operation aborts the sample with no valid_o.
- FSM states: IDLE -> MULT -> CHECK -> DIV -> OUT -> IDLE.
- Cycle T: IDLE with valid_i=1. Capture x1_i, x2_i, i1_i, i2_i.
- T+1, MULT:
  - num = x1*i1 + x2*i2, full precision signed, 2*NUM_BITS+1 bits.
  - den = i1^2 + i2^2, unsigned, 2*NUM_BITS+1 bits.
  - Both registered.
- T+2, CHECK:
  - Load dividend = |num| << FRAC_BITS.
  - If den < MIN_INTENSITY_SQ: invalid path.
  - Else if dividend >= den << (NUM_BITS-1): saturate path.
  - Else: divide path.
- T+3..T+NUM_BITS+1, DIV (NUM_BITS-1 cycles): restoring division, MSB first, producing the NUM_BITS-1 bit quotient magnitude.
  - Invalid and saturate paths still dwell in DIV for the same count, so latency is fixed.
- T+NUM_BITS+2, OUT: register pos_o, sat_o, invalid_o; valid_o=1 for this cycle only.
- Latency: fixed NUM_BITS+2 cycles from valid_i to valid_o (26 at default).
- busy_o: high T+1 through T+NUM_BITS+2 inclusive. Earliest next accepted valid_i is T+NUM_BITS+3.
- Sign and rounding: quotient sign = sign(num); magnitude truncated toward zero. A zero magnitude gives pos_o = 0, never -0 ambiguity.
- Saturation is symmetric: pos_o = +(2^(NUM_BITS-1)-1) if num > 0, else -(2^(NUM_BITS-1)-1). Sets sat_o=1.
- Invalid: pos_o = 0, invalid_o=1, sat_o=0. Invalid has priority over saturation.
- valid_i while busy_o=1 (including the OUT cycle): sample dropped, overrun_o set. The in-flight result is unaffected.
- Simultaneous valid_i and reset_ni low: reset wins, nothing captured.

Optional Feature:
- QPD_NORM_ROUND_EN defined:
  - One extra quotient bit is computed; DIV lasts NUM_BITS cycles.
  - Latency becomes NUM_BITS+3 and busy_o extends by one cycle.
  - Magnitude is rounded half away from zero before the sign is applied.
  - Rounding that reaches 2^(NUM_BITS-1) saturates and sets sat_o.
- Undefined: truncation toward zero, latency NUM_BITS+2.

Test Plan (defaults, no macro):
- x1=1000, x2=0, i1=4000, i2=0, valid_i at T -> valid_o at T+26, pos_o=1048576 (0.25), sat_o=0, invalid_o=0, busy_o high T+1..T+26.
- x1=0, x2=-3000, i1=3000, i2=4000 -> num=-12000000, den=25000000, pos_o=-2013265 (-2013266 with QPD_NORM_ROUND_EN, at T+27).
- x1=500, x2=-500, i1=0, i2=0 -> pos_o=0, invalid_o=1, sat_o=0, valid_o at T+26.
- x1=40000, i1=1000, x2=i2=0 -> pos_o=8388607, sat_o=1. Repeat with x1=-40000 -> pos_o=-8388607, sat_o=1.
- Vector of test 1 at T, second valid_i at T+5 and at T+26 -> first result unchanged at T+26, both later strobes dropped, overrun_o=1 from T+6 until reset; valid_i at T+27 accepted normally.
- Start test 2 at T, reset_ni low T+10..T+11 -> all outputs 0 from T+10, no valid_o; test 1 issued after release yields 1048576 at +26.

Source files
------------

// File: rtl/qpd_position_normalizer_if.sv
// qpd_position_normalizer_if: sample/result bundle between the QPD demodulator, the normalizer and its consumer
interface qpd_position_normalizer_if #(
  parameter int NUM_BITS = 24
);
  logic                       valid_i;
  logic signed [NUM_BITS-1:0] x1_i;
  logic signed [NUM_BITS-1:0] x2_i;
  logic signed [NUM_BITS-1:0] i1_i;
  logic signed [NUM_BITS-1:0] i2_i;
  logic signed [NUM_BITS-1:0] pos_o;
  logic                       valid_o;
  logic                       busy_o;
  logic                       sat_o;
  logic                       invalid_o;
  logic                       overrun_o;
  modport master (
    output valid_i, x1_i, x2_i, i1_i, i2_i,
    input  pos_o, valid_o, busy_o, sat_o, invalid_o, overrun_o
  );
  modport slave (
    input  valid_i, x1_i, x2_i, i1_i, i2_i,
    output pos_o, valid_o, busy_o, sat_o, invalid_o, overrun_o
  );
endinterface

// File: rtl/qpd_position_normalizer.sv
// qpd_position_normalizer: pos = (x1*i1 + x2*i2) / (i1^2 + i2^2) in fixed point; QPD_NORM_ROUND_EN adds round-half-away-from-zero
module qpd_position_normalizer #(
  parameter int NUM_BITS         = 24,
  parameter int FRAC_BITS        = 22,
  parameter int MIN_INTENSITY_SQ = 1
) (
  input logic                      clk_i,
  input logic                      reset_ni,
  qpd_position_normalizer_if.slave bus
);
  localparam int W  = 2*NUM_BITS+1;
`ifdef QPD_NORM_ROUND_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  // quotient bits produced; the rounding build carries one extra half-LSB bit
  localparam int QB = NUM_BITS-1+RB;
  localparam int DW = W+FRAC_BITS+NUM_BITS+1;
  localparam int CW = $clog2(QB);
  localparam logic [W-1:0] MIN_SQ = W'(MIN_INTENSITY_SQ);
  localparam logic signed [NUM_BITS-1:0] PMAX = {1'b0, {(NUM_BITS-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, MULT, CHECK, DIV, OUT} state_t;

  state_t                     state;
  logic signed [NUM_BITS-1:0] x1, x2, i1, i2;
  logic signed [W-1:0]        num;
  logic [W-1:0]               den;
  logic [DW-1:0]              rem, dsh;
  logic [QB-1:0]              q;
  logic [CW-1:0]              cnt;
  logic                       neg, sat, inv;

  logic signed [W-1:0]        x1e, x2e, i1e, i2e;
  logic [W-1:0]               mag;
  logic [DW-1:0]              dvd, dlim;
  logic                       bit_q;
  logic [QB-1:0]              q_next;
  logic [NUM_BITS-2:0]        qm;
  logic                       qsat;
  logic signed [NUM_BITS-1:0] mag_s, res;

  assign x1e    = W'(x1);
  assign x2e    = W'(x2);
  assign i1e    = W'(i1);
  assign i2e    = W'(i2);
  assign mag    = num[W-1] ? -num : num;
  assign dvd    = DW'(mag) << FRAC_BITS;
  assign dlim   = DW'(den) << (NUM_BITS-1);
  assign bit_q  = rem >= dsh;
  assign q_next = {q[QB-2:0], bit_q};
`ifdef QPD_NORM_ROUND_EN
  // halve the doubled quotient, adding back its LSB: ties go away from zero on the magnitude
  logic [QB-1:0] rnd;
  assign rnd  = {1'b0, q_next[QB-1:1]} + QB'(q_next[0]);
  assign qm   = rnd[NUM_BITS-2:0];
  assign qsat = rnd[NUM_BITS-1];
`else
  assign qm   = q_next;
  assign qsat = 1'b0;
`endif
  assign mag_s = {1'b0, qm};
  assign res   = inv ? '0 : (sat || qsat) ? (neg ? -PMAX : PMAX) : (neg ? -mag_s : mag_s);

  // sequencer and datapath: capture, multiply, classify, fixed-length restoring divide, publish
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= IDLE;
      x1            <= '0;
      x2            <= '0;
      i1            <= '0;
      i2            <= '0;
      num           <= '0;
      den           <= '0;
      rem           <= '0;
      dsh           <= '0;
      q             <= '0;
      cnt           <= '0;
      neg           <= 1'b0;
      sat           <= 1'b0;
      inv           <= 1'b0;
      bus.pos_o     <= '0;
      bus.valid_o   <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.sat_o     <= 1'b0;
      bus.invalid_o <= 1'b0;
      bus.overrun_o <= 1'b0;
    end else begin
      if (bus.valid_i && state != IDLE) bus.overrun_o <= 1'b1;
      case (state)
        IDLE: if (bus.valid_i) begin
          x1         <= bus.x1_i;
          x2         <= bus.x2_i;
          i1         <= bus.i1_i;
          i2         <= bus.i2_i;
          bus.busy_o <= 1'b1;
          state      <= MULT;
        end
        MULT: begin
          num   <= x1e*i1e + x2e*i2e;
          den   <= i1e*i1e + i2e*i2e;
          state <= CHECK;
        end
        CHECK: begin
          neg   <= num[W-1];
          inv   <= den < MIN_SQ;
          sat   <= dvd >= dlim;
          rem   <= dvd << RB;
          dsh   <= DW'(den) << (QB-1);
          q     <= '0;
          cnt   <= CW'(QB-1);
          state <= DIV;
        end
        DIV: begin
          rem <= bit_q ? rem - dsh : rem;
          dsh <= dsh >> 1;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.pos_o     <= res;
            bus.sat_o     <= !inv && (sat || qsat);
            bus.invalid_o <= inv;
            bus.valid_o   <= 1'b1;
            state         <= OUT;
          end
        end
        OUT: begin
          bus.valid_o <= 1'b0;
          bus.busy_o  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qpd_position_normalizer.sv
// tb_qpd_position_normalizer: directed vectors checked against an arithmetic reference model every cycle
module tb_qpd_position_normalizer;
  localparam int N = 24;
  localparam int F = 22;
  localparam int MIN_SQ = 1;
`ifdef QPD_NORM_ROUND_EN
  localparam int LAT = N+3;
  localparam int T2_POS = -2013266;
`else
  localparam int LAT = N+2;
  localparam int T2_POS = -2013265;
`endif
  localparam logic signed [N-1:0] PMAX = (1 <<< (N-1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpd_position_normalizer_if #(.NUM_BITS(N)) bus ();

  qpd_position_normalizer #(
    .NUM_BITS(N), .FRAC_BITS(F), .MIN_INTENSITY_SQ(MIN_SQ)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: exact rational result from wide integer arithmetic
  function automatic void model(input logic signed [N-1:0] x1, x2, i1, i2,
                                output logic signed [N-1:0] p, output logic s, output logic iv);
    logic signed [127:0] num, den, a, qq;
    num = 128'(x1)*128'(i1) + 128'(x2)*128'(i2);
    den = 128'(i1)*128'(i1) + 128'(i2)*128'(i2);
    p = '0; s = 1'b0; iv = 1'b0;
    if (den < MIN_SQ) iv = 1'b1;
    else begin
      a = (num < 0 ? -num : num) << F;
`ifdef QPD_NORM_ROUND_EN
      qq = (2*a + den) / (2*den);
`else
      qq = a / den;
`endif
      if (qq >= (128'sd1 << (N-1))) begin
        s = 1'b1;
        p = num > 0 ? PMAX : -PMAX;
      end else p = N'(num < 0 ? -qq : qq);
    end
  endfunction

  int ec = 0;
  int e_acc = -1000;
  logic signed [N-1:0] pend_p, held_p;
  logic pend_s, pend_i, held_s, held_i, m_ovr;

  // model of the block's externally visible timing and results
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_acc = -1000;
      held_p = '0; held_s = 1'b0; held_i = 1'b0; m_ovr = 1'b0;
    end else begin
      ec++;
      if (ec == e_acc+LAT-1) begin
        held_p = pend_p; held_s = pend_s; held_i = pend_i;
      end
      if (bus.valid_i) begin
        if (ec >= e_acc+LAT+1) begin
          model(bus.x1_i, bus.x2_i, bus.i1_i, bus.i2_i, pend_p, pend_s, pend_i);
          e_acc = ec;
        end else m_ovr = 1'b1;
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) if (chk_en) begin
    if (!rst_n) begin
      check("rst_pos", bus.pos_o, 0);
      check("rst_valid", bus.valid_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_sat", bus.sat_o, 0);
      check("rst_inv", bus.invalid_o, 0);
      check("rst_ovr", bus.overrun_o, 0);
    end else begin
      check("valid", bus.valid_o, ec == e_acc+LAT-1);
      check("busy", bus.busy_o, ec >= e_acc && ec <= e_acc+LAT-1);
      check("pos", bus.pos_o, held_p);
      check("sat", bus.sat_o, held_s);
      check("inv", bus.invalid_o, held_i);
      check("ovr", bus.overrun_o, m_ovr);
    end
  end

  task automatic drive(input int x1, x2, i1, i2);
    bus.x1_i = N'(x1); bus.x2_i = N'(x2); bus.i1_i = N'(i1); bus.i2_i = N'(i2);
  endtask

  // waits for valid_o counting cycles after the capture cycle
  task automatic wait_result(input string nm);
    int k;
    bit got;
    got = 1'b0;
    for (k = 1; k <= LAT+10; k++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin got = 1'b1; break; end
    end
    check({nm, "_latency"}, got ? k : -1, LAT);
  endtask

  task automatic run(input string nm, input int x1, x2, i1, i2, input bit lit, input int ep, es, ei);
    @(posedge clk); #1;
    drive(x1, x2, i1, i2);
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    wait_result(nm);
    if (lit) begin
      check({nm, "_pos"}, bus.pos_o, ep);
      check({nm, "_sat"}, bus.sat_o, es);
      check({nm, "_inv"}, bus.invalid_o, ei);
    end
  endtask

  initial begin
    int seen;
    bus.valid_i = 1'b0;
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run("t1",    1000,     0,   4000,       0, 1, 1048576, 0, 0);
    run("t2",       0, -3000,   3000,    4000, 1, T2_POS,  0, 0);
    run("inv",    500,  -500,      0,       0, 1, 0,       0, 1);
    run("satp", 40000,     0,   1000,       0, 1, 8388607, 1, 0);
    run("satn",-40000,     0,   1000,       0, 1, -8388607,1, 0);
    run("unit",     1,     0,      1,       0, 1, 4194304, 0, 0);
    run("edge",     2,     0,      1,       0, 1, 8388607, 1, 0);
    run("nunit",    0,    -1,      0,       1, 1, -4194304,0, 0);
    run("zero",     0,     0,      5,       5, 1, 0,       0, 0);
    run("mix",  -1234,  5678, 300000, -200000, 0, 0,       0, 0);

    // overrun: strobes at T+5 and T+26 dropped, T+27 accepted
    @(posedge clk); #1;
    drive(1000, 0, 4000, 0);
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.valid_i = 1'b1;
    drive(40000, 0, 1000, 0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("ovr_set", bus.overrun_o, 1);
    repeat (20) @(posedge clk);
    #1 bus.valid_i = 1'b1;
    @(negedge clk);
    check("ovr_first_valid", bus.valid_o, 1);
    check("ovr_first_pos", bus.pos_o, 1048576);
    @(posedge clk); #1;
    drive(0, -3000, 3000, 4000);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    wait_result("ovr_next");
    check("ovr_next_pos", bus.pos_o, T2_POS);
    check("ovr_sticky", bus.overrun_o, 1);

    // reset mid-operation, with a strobe presented while reset is held
    @(posedge clk); #1;
    drive(0, -3000, 3000, 4000);
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", bus.busy_o, 0);
    check("rst_mid_ovr", bus.overrun_o, 0);
    @(posedge clk); #1;
    bus.valid_i = 1'b1;
    drive(1000, 0, 4000, 0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT+5) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) seen++;
    end
    check("rst_no_valid", seen, 0);
    run("post_rst", 1000, 0, 4000, 0, 1, 1048576, 0, 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
